// File: rtl/sensor_alarm_pkg.sv
// Shared types and helpers for the voting sensor alarm block.
package sensor_alarm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_ALARM = 2'd2
    } alarm_state_t;

    // Sized for the largest supported channel count; callers zero-extend.
    function automatic logic [4:0] popcount(input logic [15:0] i_vec);
        logic [4:0] v_sum;
        v_sum = '0;
        for (int k = 0; k < 16; k++) begin
            v_sum = v_sum + 5'(i_vec[k]);
        end
        return v_sum;
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// One sensor lane: 2-flop synchroniser followed by a stability counter.
module sensor_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic db
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          r_meta;
    logic          r_sync;
    logic          r_db;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_db   <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_meta <= raw;
            r_sync <= r_meta;
            if (r_sync == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                // Mismatch held long enough: accept the new level.
                r_db  <= ~r_db;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign db = r_db;

endmodule

// File: rtl/sensor_vote_alarm.sv
// N-channel debounced sensor voting with latched alarms and an arm/disarm FSM.
module sensor_vote_alarm
    import sensor_alarm_pkg::*;
#(
    parameter int N_SENSORS       = 3,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int VOTE_THRESHOLD  = 2,
    localparam int CNT_W          = $clog2(N_SENSORS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_SENSORS-1:0] sensor,
    input  logic                 arm,
    input  logic                 disarm,
    input  logic                 ack,
    output logic [N_SENSORS-1:0] sensor_db,
    output logic [CNT_W-1:0]     active_count,
    output logic [N_SENSORS-1:0] alarm,
    output logic [1:0]           state
);

    logic [N_SENSORS-1:0] w_db;
    logic [CNT_W-1:0]     w_pop;
    logic [N_SENSORS-1:0] w_trig;
    logic [N_SENSORS-1:0] w_alarm_nxt;
    alarm_state_t         w_state_nxt;

    alarm_state_t         r_state;
    logic [N_SENSORS-1:0] r_alarm;
    logic [CNT_W-1:0]     r_count;

    for (genvar g = 0; g < N_SENSORS; g++) begin : g_lane
        sensor_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk(clk),
            .rst(rst),
            .raw(sensor[g]),
            .db (w_db[g])
        );
    end

    assign w_pop = CNT_W'(popcount(16'(w_db)));

    // A channel votes on the others only, so its own level is removed first.
    always_comb begin
        w_trig = '0;
        for (int i = 0; i < N_SENSORS; i++) begin
            w_trig[i] = (w_pop - CNT_W'(w_db[i])) >= CNT_W'(VOTE_THRESHOLD);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_alarm_nxt = r_alarm;
        if (disarm) begin
            w_state_nxt = ST_IDLE;
            w_alarm_nxt = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_alarm_nxt = '0;
                    if (arm) w_state_nxt = ST_ARMED;
                end
                ST_ARMED: begin
                    w_alarm_nxt = '0;
                    if (|w_trig) begin
                        w_state_nxt = ST_ALARM;
                        w_alarm_nxt = w_trig;
                    end
                end
                ST_ALARM: begin
                    if (ack) begin
                        w_alarm_nxt = w_trig;
                        if (~|w_trig) w_state_nxt = ST_ARMED;
                    end else begin
                        w_alarm_nxt = r_alarm | w_trig;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_alarm_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_alarm <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_alarm <= w_alarm_nxt;
            r_count <= w_pop;
        end
    end

    assign sensor_db    = w_db;
    assign active_count = r_count;
    assign alarm        = r_alarm;
    assign state        = r_state;

endmodule

// File: doc/sensor_vote_alarm.md
Name: sensor_vote_alarm

Overview:
- Parametrised successor to the team's 3-sensor priority alarm block.
- Takes N raw sensor inputs and synchronises and debounces each one.
- Raises per-channel alarms by vote: alarm[i] fires when at least VOTE_THRESHOLD of the other sensors are active.
- Alarms latch until acknowledged, under an arm/disarm controller. Sits between the sensor pads and the alarm/indicator drivers.

Parameters:
- N_SENSORS, 3, number of sensor channels (2..16).
- DEBOUNCE_CYCLES, 4, consecutive stable cycles needed before a debounced level changes (>=1).
- VOTE_THRESHOLD, 2, minimum number of other active sensors that trigger alarm[i] (1..N_SENSORS-1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- sensor  in  N_SENSORS  raw asynchronous sensor levels.
- arm  in  1  single-cycle request: IDLE->ARMED.
- disarm  in  1  single-cycle request: any state->IDLE.
- ack  in  1  single-cycle alarm acknowledge.
- sensor_db  out  N_SENSORS  debounced sensor levels.
- active_count  out  $clog2(N_SENSORS+1)  number of set sensor_db bits (registered).
- alarm  out  N_SENSORS  latched per-channel alarms.
- state  out  2  FSM state: 0 IDLE, 1 ARMED, 2 ALARM.

Behaviour:
- Reset (async assert, released on clk): synchronisers, debounced levels, counters, alarm, active_count = 0; state = IDLE.
- Per channel:
  - 2-flop synchroniser, then a debounce counter.
  - Counter increments while the synchronised value differs from sensor_db[i] and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 with a mismatch, sensor_db[i] toggles and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES cycles never reach sensor_db.
- Latency:
  - A raw level held stable appears on sensor_db at clock edge 2+DEBOUNCE_CYCLES after the first sampling edge.
  - active_count and alarm update one edge later.
- Trigger (combinational): trig[i] = 1 when popcount(sensor_db) - sensor_db[i] >= VOTE_THRESHOLD.
- FSM, evaluated in priority order disarm > ack > arm/trigger:
  - IDLE: alarm held 0; trig ignored. arm -> ARMED.
  - ARMED: if any trig -> ALARM, with alarm <= trig on that edge. arm is ignored here.
  - ALARM:
    - alarm <= alarm | trig every cycle; new channels accumulate.
    - On ack: alarm <= trig, so only currently triggering channels remain.
    - If trig == 0 on the ack cycle -> ARMED with alarm = 0.
  - disarm in any state -> IDLE, alarm <= 0 on the same edge.
- Simultaneous events:
  - arm with disarm: disarm wins.
  - ack with disarm: disarm wins.
  - ack with a new trigger: the triggered bit stays set and the state stays ALARM.
  - arm in ARMED or ALARM, and ack outside ALARM, have no effect.
- Reset mid-alarm: all outputs clear immediately (async). The block returns to IDLE and requires a new arm.
- State encoding 3 is unreachable; if ever entered, next state = IDLE.
- Width rules: popcount is computed at the active_count width; the comparison is unsigned. No overflow is possible for N_SENSORS <= 16.

Decomposition:
- Package sensor_alarm_pkg holds:
  - state typedef/localparams ST_IDLE=2'd0, ST_ARMED=2'd1, ST_ALARM=2'd2;
  - a popcount function.
- Sub-module sensor_debounce, instantiated N_SENSORS times in a generate loop:
  - ports clk, rst, raw, db;
  - parameter DEBOUNCE_CYCLES;
  - contains the synchroniser and counter.
- Top level holds the trigger logic, FSM, and alarm/active_count registers.

Test Plan:
- Reset/idle: assert rst mid-run with sensor=3'b111 -> alarm=0, state=0, sensor_db=0 immediately. After release with arm never pulsed -> alarm stays 3'b000 for 50 cycles.
- Debounce: defaults, armed. Sensor[0] pulses high 3 cycles -> sensor_db stays 0. Sensor[0] held high -> sensor_db[0]=1 at edge 6 after first sample; active_count=1 at edge 7.
- Vote, defaults, armed, sensor=3'b110 held:
  - alarm=3'b001, state=2 at edge 7.
  - sensor=3'b111 -> alarm=3'b111.
  - Matches the legacy 3-sensor priority mapping except c.
- Ack:
  - With alarm=3'b111, drop sensor to 3'b001 and wait for debounce, then pulse ack -> alarm=3'b000, state=1.
  - Repeat with sensor=3'b011 -> alarm=3'b100, state stays 2.
- Simultaneous: in ALARM, pulse ack and disarm together -> state=0, alarm=0. From IDLE, arm and disarm together -> state stays 0.
- Parametrised: N_SENSORS=5, VOTE_THRESHOLD=3, DEBOUNCE_CYCLES=1, sensor=5'b01110 -> alarm=5'b10001 at edge 4; active_count=3.
